// File: rtl/inst_loader.sv
// Byte-stream instruction loader: parses [N][N words][xor checksum] frames (MSB first)
// and writes each assembled word into the fetcher's load port while holding the core.
module inst_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter int          CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             load,
    output logic [31:0]      load_addr,
    output logic [31:0]      load_inst,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t           state, state_next;
    logic [1:0]       byte_cnt;
    logic [23:0]      shreg;
    logic [7:0]       csum;
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] idx_inc;
    logic [31:0]      assembled;
    logic             xfer;
    logic             last_byte;
    logic             len_bad;
    logic             begin_frame;

    // Handshake: a byte moves on a clk edge where byte_valid && byte_ready; the source
    // must hold byte_data stable while byte_valid is high and byte_ready is low.
    assign xfer        = byte_valid && byte_ready;
    assign last_byte   = (byte_cnt == 2'd3);
    assign assembled   = {shreg, byte_data};
    assign len_bad     = (assembled == 32'd0) || (assembled > 32'(MAX_WORDS));
    assign begin_frame = start && ((state == S_IDLE) || (state == S_ERR));
    assign idx_inc     = idx + CNT_W'(1);
    assign words_loaded = idx;
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = S_HDR;
            S_HDR:   if (xfer && last_byte) state_next = len_bad ? S_ERR : S_DATA;
            S_DATA:  if (xfer && last_byte) state_next = S_WRITE;
            S_WRITE: state_next = (idx_inc == n_words) ? S_CSUM : S_DATA;
            S_CSUM:  if (xfer) state_next = (byte_data == csum) ? S_DONE : S_ERR;
            S_DONE:  state_next = S_IDLE;
            S_ERR:   if (start) state_next = S_HDR;
            default: state_next = S_IDLE;
        endcase
    end

    // ERR keeps the core held so a partially loaded image never runs.
    always_comb begin
        byte_ready = 1'b0;
        load       = 1'b0;
        busy       = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state)
            S_HDR, S_DATA, S_CSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_hold   = 1'b1;
            end
            S_WRITE: begin
                load     = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            S_DONE: begin
                done     = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            S_ERR: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt  <= 2'd0;
            shreg     <= 24'd0;
            csum      <= 8'd0;
            n_words   <= '0;
            idx       <= '0;
            load_addr <= 32'd0;
            load_inst <= 32'd0;
        end else if (begin_frame) begin
            byte_cnt <= 2'd0;
            csum     <= 8'd0;
            idx      <= '0;
        end else begin
            if (xfer) begin
                shreg    <= assembled[23:0];
                byte_cnt <= byte_cnt + 2'd1;
                if (state != S_CSUM) csum <= csum ^ byte_data;
            end
            if (xfer && last_byte && (state == S_HDR)) n_words <= assembled[CNT_W-1:0];
            // Address/word are latched here so they are stable for the whole WRITE cycle.
            if (xfer && last_byte && (state == S_DATA)) begin
                load_inst <= assembled;
                load_addr <= BASE_ADDR + (32'(idx) << 2);
            end
            if (state == S_WRITE) idx <= idx_inc;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: frame builder, byte driver, per-cycle load scoreboard.
module tb_inst_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;
    localparam int          CW   = 11;
    localparam int          BUDGET = 20000;

    logic          clk;
    logic          rst;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          load;
    logic [31:0]   load_addr;
    logic [31:0]   load_inst;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] words_loaded;
    logic [2:0]    dbg_state;

    inst_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .load(load), .load_addr(load_addr), .load_inst(load_inst),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] frame_words [MAXW];
    logic [7:0]  fbytes [$];
    logic [31:0] exp_q [$];
    logic [31:0] exp_addr_q [$];
    logic [7:0]  model_csum;
    int          cur_n  = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame model: header N, N words, xor of all preceding bytes (flipped when !good).
    task automatic build_frame(input int n, input bit hdr_only, input bit good);
        logic [31:0] nv;
        logic [31:0] w;
        logic [7:0]  c;
        fbytes.delete();
        nv = n;
        c  = 8'h00;
        for (int b = 3; b >= 0; b--) begin
            fbytes.push_back(nv[8*b +: 8]);
            c ^= nv[8*b +: 8];
        end
        if (!hdr_only) begin
            for (int k = 0; k < n; k++) begin
                w = frame_words[k];
                for (int b = 3; b >= 0; b--) begin
                    fbytes.push_back(w[8*b +: 8]);
                    c ^= w[8*b +: 8];
                end
            end
            fbytes.push_back(good ? c : (c ^ 8'h01));
        end
        model_csum = c;
    endtask

    // Scoreboard: a load is due exactly one cycle after the last byte of each data word.
    initial begin : compare
        int acc;
        bit pend;
        acc  = 0;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst) begin
                pend = 1'b0;
            end else begin
                chk("load_strobe", {31'd0, load}, {31'd0, pend});
                if (load) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL load_unexpected: got load at %h expected no load", load_addr);
                    end else begin
                        chk("load_addr", load_addr, exp_addr_q.pop_front());
                        chk("load_inst", load_inst, exp_q.pop_front());
                    end
                end
                if (busy && !done) chk("byte_ready", {31'd0, byte_ready}, {31'd0, !load});
                if (start && !busy) begin
                    acc  = 0;
                    pend = 1'b0;
                    exp_q.delete();
                    exp_addr_q.delete();
                    if (cur_n >= 1 && cur_n <= MAXW) begin
                        for (int k = 0; k < cur_n; k++) begin
                            exp_q.push_back(frame_words[k]);
                            exp_addr_q.push_back(BASE + 32'(4 * k));
                        end
                    end
                end else if (byte_valid && byte_ready) begin
                    pend = (cur_n >= 1) && (cur_n <= MAXW) && (acc >= 4) &&
                           (acc < 4 + 4 * cur_n) && (acc % 4 == 3);
                    acc++;
                end else begin
                    pend = 1'b0;
                end
            end
        end
    end

    // Driver: start pulse, then present bytes (optionally with random valid gaps).
    task automatic run_frame(input string tag, input int n, input bit hdr_only, input bit good,
                             input bit rand_valid, input int start_mid, input int abort_at,
                             input bit exp_done, input int exp_wl);
        int i;
        int cyc;
        bit acc;
        bit mid_done;
        cur_n = n;
        build_frame(n, hdr_only, good);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hold_after_start"}, {31'd0, cpu_hold}, 32'd1);
        chk({tag, "_err_cleared"}, {31'd0, error}, 32'd0);
        i = 0;
        cyc = 0;
        mid_done = 1'b0;
        while (i < fbytes.size() && i != abort_at && cyc < BUDGET) begin
            byte_valid = rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
            byte_data  = fbytes[i];
            start      = (i == start_mid) && !mid_done;
            if (start) mid_done = 1'b1;
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) i++;
            cyc++;
        end
        byte_valid = 1'b0;
        if (cyc >= BUDGET) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got %0d bytes accepted expected %0d", tag, i, fbytes.size());
            return;
        end
        if (abort_at >= 0) return;
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, !exp_done});
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_wl));
        chk({tag, "_pending_loads"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hold_end"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
        chk({tag, "_error_end"}, {31'd0, error}, {31'd0, !exp_done});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_load"}, {31'd0, load}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
        chk({tag, "_load_addr"}, load_addr, 32'd0);
        chk({tag, "_load_inst"}, load_inst, 32'd0);
    endtask

    initial begin : main
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // single word, checksum 2C
        frame_words[0] = 32'h2008_0005;
        run_frame("single", 1, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1, 1);
        chk("single_model_csum", {24'd0, model_csum}, 32'h0000_002C);
        chk("single_last_addr", load_addr, 32'h0000_0000);
        chk("single_last_inst", load_inst, 32'h2008_0005);

        // same frame, checksum 2D
        run_frame("badsum", 1, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 1);

        // length limits (each started from ERR)
        run_frame("zero_len", 0, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0, 0);
        run_frame("too_long", MAXW + 1, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0, 0);

        // restart from ERR, random stalls, stray start mid-frame
        frame_words[0] = 32'h1122_3344;
        frame_words[1] = 32'hDEAD_BEEF;
        frame_words[2] = 32'h0000_0013;
        run_frame("stall3", 3, 1'b0, 1'b1, 1'b1, 6, -1, 1'b1, 3);
        chk("stall3_last_addr", load_addr, 32'h0000_0008);
        chk("stall3_last_inst", load_inst, 32'h0000_0013);

        // reset after header + 2 data bytes
        frame_words[0] = 32'hCAFE_F00D;
        frame_words[1] = 32'h0BAD_1DEA;
        run_frame("abort", 2, 1'b0, 1'b1, 1'b0, -1, 6, 1'b1, 0);
        mon_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        frame_words[0] = 32'hA5A5_0001;
        frame_words[1] = 32'h5A5A_0002;
        run_frame("after_reset", 2, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1, 2);
        chk("after_reset_last_addr", load_addr, 32'h0000_0004);

        // largest legal frame
        for (int k = 0; k < MAXW; k++) frame_words[k] = {k[15:0], ~k[15:0]};
        run_frame("max", MAXW, 1'b0, 1'b1, 1'b0, -1, -1, 1'b1, MAXW);
        chk("max_last_addr", load_addr, 32'h0000_0FFC);
        chk("max_last_inst", load_inst, 32'h03FF_FC00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
